// File: rtl/stream_xbar_demux.sv
// stream_xbar_demux
// Routes one valid/ready packet stream to one of NUM_OUTPUT output ports.
// The destination is taken from the first beat of each packet and held for
// the rest of that packet. Packets addressed to a port that does not exist
// are consumed, discarded and counted. A single output register gives
// 1-cycle latency and full throughput.
//
// Handshake: a beat moves on an interface at a rising edge where valid and
// ready are both 1. Once a valid is raised, it and its payload stay stable
// until that handshake. s_ready_o never depends on s_valid_i or s_dest_i.
module stream_xbar_demux #(
  parameter int NUM_OUTPUT = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // input stream
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  input  logic [DEST_WIDTH-1:0] s_dest_i,
  // output ports (payload and last shared, valid per port)
  output logic [NUM_OUTPUT-1:0] m_valid_o,
  input  logic [NUM_OUTPUT-1:0] m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  // status and debug
  output logic [15:0]           drop_cnt_o,
  output logic [1:0]            dbg_state_o
);

  // Port count widened by one bit so every dest value compares cleanly.
  localparam logic [DEST_WIDTH:0] NUM_OUT_W = (DEST_WIDTH + 1)'(NUM_OUTPUT);

  // Packet state: IDLE waits for a first beat, FWD forwards the body of a
  // routed packet, DROP swallows the body of a discarded packet.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DEST_WIDTH-1:0] dest_q, dest_d;

  // Output register
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic [DEST_WIDTH-1:0] out_sel_q;

  logic [15:0]           drop_cnt_q;

  // Decoded control
  logic                  out_hs;
  logic                  accept;
  logic                  dest_ok;
  logic                  load;
  logic [DEST_WIDTH-1:0] load_sel;
  logic                  drop_inc;

  // Decode the registered port index into the one-hot per-port valid.
  always_comb begin
    m_valid_o = '0;
    for (int k = 0; k < NUM_OUTPUT; k++) begin
      m_valid_o[k] = out_valid_q && (out_sel_q == DEST_WIDTH'(k));
    end
  end

  // Output handshake on the selected port; other ports' ready is masked
  // out because their valid bit is 0.
  always_comb begin
    out_hs = |(m_valid_o & m_ready_i);
  end

  // Input ready: forced low in reset, always high while discarding,
  // otherwise the register must be empty or draining this cycle. A dropped
  // first beat may wait behind a pending register beat in IDLE.
  always_comb begin
    if (rst_i) begin
      s_ready_o = 1'b0;
    end else if (state_q == DROP) begin
      s_ready_o = 1'b1;
    end else begin
      s_ready_o = ~out_valid_q | out_hs;
    end
  end

  // Accepted beat and destination range check.
  always_comb begin
    accept  = s_valid_i & s_ready_o;
    dest_ok = ({1'b0, s_dest_i} < NUM_OUT_W);
  end

  // Next-state logic and per-beat actions for the packet FSM.
  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    load     = 1'b0;
    load_sel = dest_q;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dest_ok) begin
            load     = 1'b1;
            load_sel = s_dest_i;
            dest_d   = s_dest_i;
            state_d  = s_last_i ? IDLE : FWD;
          end else begin
            drop_inc = 1'b1;
            state_d  = s_last_i ? IDLE : DROP;
          end
        end
      end
      FWD: begin
        if (accept) begin
          load     = 1'b1;
          load_sel = dest_q;
          if (s_last_i) begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (accept && s_last_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and locked destination.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  // Output register: a load wins over a drain so back-to-back beats (even
  // to different ports) flow without a bubble; otherwise hold until the
  // handshake clears valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= s_data_i;
      out_last_q  <= s_last_i;
      out_sel_q   <= load_sel;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  // Discarded-packet counter, saturating; bumps once per dropped packet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // Drive registered outputs.
  always_comb begin
    m_data_o    = out_data_q;
    m_last_o    = out_last_q;
    drop_cnt_o  = drop_cnt_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_stream_xbar_demux.sv
// Directed bench for stream_xbar_demux with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; registered outputs are
// checked at that point, combinational ready one more unit later.
module tb_stream_xbar_demux;

  localparam int NO = 4;
  localparam int DW = 32;
  localparam int TW = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic [TW-1:0] s_dest;
  logic [NO-1:0] m_valid;
  logic [NO-1:0] m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [15:0]   drop_cnt;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  stream_xbar_demux #(
    .NUM_OUTPUT(NO),
    .DATA_WIDTH(DW),
    .DEST_WIDTH(TW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_data_i   (s_data),
    .s_last_i   (s_last),
    .s_dest_i   (s_dest),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_last_o   (m_last),
    .drop_cnt_o (drop_cnt),
    .dbg_state_o(dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [TW-1:0] d, input logic [DW-1:0] x, input logic l);
    s_valid = v;
    s_dest  = d;
    s_data  = x;
    s_last  = l;
  endtask

  initial begin
    rst = 1'b1;
    m_ready = '1;
    drive(1'b0, '0, '0, 1'b0);

    // reset state
    tick();
    tick();
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {28'd0, m_valid}, 32'd0);
    check("rst_drop", {16'd0, drop_cnt}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;
    #1;
    check("idle_s_ready", {31'd0, s_ready}, 32'd1);
    tick();

    // single-beat routing to port 2
    drive(1'b1, 4'd2, 32'hA5A5_0001, 1'b1);
    #1;
    check("sb_s_ready", {31'd0, s_ready}, 32'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("sb_valid", {28'd0, m_valid}, 32'h4);
    check("sb_data", m_data, 32'hA5A5_0001);
    check("sb_last", {31'd0, m_last}, 32'd1);
    tick();
    check("sb_valid_clr", {28'd0, m_valid}, 32'h0);

    // destination lock: dest 1 on beat 0, dest 3 on the body
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) ? 4'd1 : 4'd3, 32'h10 + i, i == 3);
      tick();
      check("lock_valid", {28'd0, m_valid}, 32'h2);
      check("lock_data", m_data, 32'h10 + i);
      check("lock_last", {31'd0, m_last}, (i == 3) ? 32'd1 : 32'd0);
      check("lock_state", {30'd0, dbg_state}, (i == 3) ? {30'd0, ST_IDLE} : {30'd0, ST_FWD});
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("lock_end", {28'd0, m_valid}, 32'h0);

    // back-pressure on port 0 during a 3-beat packet
    drive(1'b1, 4'd0, 32'h30, 1'b0);
    tick();
    check("bp_beat0", m_data, 32'h30);
    m_ready = 4'b1110;
    drive(1'b1, 4'd0, 32'h31, 1'b0);
    #1;
    check("bp_ready_lo", {31'd0, s_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", {28'd0, m_valid}, 32'h1);
      check("bp_hold_data", m_data, 32'h30);
      check("bp_hold_ready", {31'd0, s_ready}, 32'd0);
    end
    m_ready = '1;
    #1;
    check("bp_release", {31'd0, s_ready}, 32'd1);
    tick();
    check("bp_beat1", m_data, 32'h31);
    check("bp_beat1_v", {28'd0, m_valid}, 32'h1);
    drive(1'b1, 4'd0, 32'h32, 1'b1);
    tick();
    check("bp_beat2", m_data, 32'h32);
    check("bp_beat2_last", {31'd0, m_last}, 32'd1);
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("bp_end", {28'd0, m_valid}, 32'h0);

    // back-to-back single-beat packets to ports 0..3
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, TW'(p), 32'h40 + p, 1'b1);
      tick();
      check("b2b_valid", {28'd0, m_valid}, 32'd1 << p);
      check("b2b_data", m_data, 32'h40 + p);
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("b2b_end", {28'd0, m_valid}, 32'h0);

    // drop: 3-beat packet to dest 7, then 1-beat to port 0
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd7, 32'h50 + i, i == 2);
      #1;
      check("drop_s_ready", {31'd0, s_ready}, 32'd1);
      tick();
      check("drop_valid", {28'd0, m_valid}, 32'h0);
      check("drop_cnt", {16'd0, drop_cnt}, 32'd1);
      check("drop_state", {30'd0, dbg_state}, (i == 2) ? {30'd0, ST_IDLE} : {30'd0, ST_DROP});
    end
    drive(1'b1, 4'd0, 32'h55, 1'b1);
    tick();
    check("after_drop_valid", {28'd0, m_valid}, 32'h1);
    check("after_drop_data", m_data, 32'h55);
    check("after_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    // boundary: dest equal to NUM_OUTPUT is out of range
    drive(1'b1, 4'd4, 32'h56, 1'b1);
    tick();
    check("drop4_valid", {28'd0, m_valid}, 32'h0);
    check("drop4_cnt", {16'd0, drop_cnt}, 32'd2);
    check("drop4_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    drive(1'b0, '0, '0, 1'b0);
    tick();

    // reset in the middle of a 4-beat packet to port 1
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd1, 32'h60 + i, 1'b0);
      tick();
      check("rmp_data", m_data, 32'h60 + i);
    end
    rst = 1'b1;
    drive(1'b1, 4'd1, 32'h63, 1'b1);
    #1;
    check("rmp_ready_forced", {31'd0, s_ready}, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check("rmp_valid", {28'd0, m_valid}, 32'h0);
    check("rmp_drop", {16'd0, drop_cnt}, 32'd0);
    check("rmp_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    drive(1'b1, 4'd2, 32'h70, 1'b0);
    tick();
    check("rmp_new0_valid", {28'd0, m_valid}, 32'h4);
    check("rmp_new0_data", m_data, 32'h70);
    drive(1'b1, 4'd1, 32'h71, 1'b1);
    tick();
    check("rmp_new1_valid", {28'd0, m_valid}, 32'h4);
    check("rmp_new1_data", m_data, 32'h71);
    check("rmp_new1_last", {31'd0, m_last}, 32'd1);
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("rmp_end", {28'd0, m_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
